// File: rtl/reg_dump_sequencer.sv
// Dumps every word of the register bank's debug read port as a byte stream, MSB byte first,
// over a valid/ready interface. One start pulse produces REG_SIZE*BYTES handshakes and one o_done pulse.
module reg_dump_sequencer #(
  parameter int BITS_REGS = 5,
  parameter int BITS_SIZE = 32,
  parameter int REG_SIZE  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  output logic [BITS_REGS-1:0] o_addr_unitdebug,
  input  logic [BITS_SIZE-1:0] i_reg_unitdebug,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BYTES = BITS_SIZE / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BITS_REGS-1:0] LAST_ADDR = BITS_REGS'(REG_SIZE - 1);
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [BITS_REGS-1:0] addr_q;
  logic [BITS_SIZE-1:0] shift_q;
  logic [BITS_SIZE-1:0] shift_next;
  logic [CNT_W-1:0]     byte_cnt_q;
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q;
  logic                 busy_q;
  logic                 done_q;

  // Next byte lines up at the top of the word; o_tx_data is loaded from here so it stays registered.
  assign shift_next = shift_q << 8;

  // NOTE: every register in this block uses <= so all of them see the pre-edge values of each other.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          // The address has been stable for a full cycle, so the bank data is settled here.
          shift_q    <= i_reg_unitdebug;
          tx_data_q  <= i_reg_unitdebug[BITS_SIZE-1 -: 8];
          tx_valid_q <= 1'b1;
          byte_cnt_q <= '0;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (i_tx_ready) begin
            if (byte_cnt_q == LAST_BYTE) begin
              tx_valid_q <= 1'b0;
              if (addr_q == LAST_ADDR) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                addr_q  <= addr_q + BITS_REGS'(1);
                state_q <= S_LOAD;
              end
            end else begin
              shift_q    <= shift_next;
              tx_data_q  <= shift_next[BITS_SIZE-1 -: 8];
              byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_addr_unitdebug = addr_q;
  assign o_tx_data        = tx_data_q;
  assign o_tx_valid       = tx_valid_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Directed bench for reg_dump_sequencer: a behavioural register bank feeds the DUT and a
// byte scoreboard, filled when each dump is requested, is drained as handshakes complete.
module tb_reg_dump_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  addr;
  logic [31:0] reg_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        ready = 1'b0;
  logic        busy;
  logic        done;

  logic [31:0] bank     [32];
  logic [31:0] exp_bank [32];
  logic [7:0]  sb_q [$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int e0 = 0;
  int bytes_seen = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int ready_mode = 0;  // 0: high, 1: random, 2: low
  logic       prev_stall = 1'b0;
  logic       prev_rst = 1'b0;
  logic [7:0] prev_data = 8'h00;

  reg_dump_sequencer dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_start          (start),
    .o_addr_unitdebug (addr),
    .i_reg_unitdebug  (reg_data),
    .o_tx_data        (tx_data),
    .o_tx_valid       (tx_valid),
    .i_tx_ready       (ready),
    .o_busy           (busy),
    .o_done           (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign reg_data = bank[addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
  endtask

  task automatic push_dump();
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--)
        sb_q.push_back(exp_bank[r][8*b +: 8]);
  endtask

  always @(negedge clk) begin
    if (prev_stall && !prev_rst) begin
      check("hold_valid", 32'(tx_valid), 32'd1);
      check("hold_data", 32'(tx_data), 32'(prev_data));
    end
    prev_stall = tx_valid && !ready;
    prev_rst   = rst;
    prev_data  = tx_data;
    if (tx_valid && ready && !rst) begin
      if (sb_q.size() == 0) begin
        check("spurious_byte_queue_depth", 32'(sb_q.size()), 32'd1);
      end else begin
        check($sformatf("byte%0d", bytes_seen), 32'(tx_data), 32'(sb_q.pop_front()));
      end
      bytes_seen++;
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  // One complete dump: optional extra start pokes, a mid-dump bank write, and an initial stall.
  task automatic run_dump(input string tag, input int rmode, input bit poke,
                          input bit wr_test, input int stall);
    int  base_bytes;
    int  base_done;
    bit  seen;
    bit  written;
    base_bytes = bytes_seen;
    base_done  = done_cnt;
    seen       = 1'b0;
    written    = 1'b0;
    push_dump();
    ready_mode = (stall > 0) ? 2 : rmode;
    ready      = (ready_mode == 0);
    start      = 1'b1;
    e0         = cyc + 1;
    step();
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      start = poke && (i == 20 || i == 77 || i == 140);
      if (stall > 0 && i == stall) begin
        check({tag, "_stall_data"}, 32'(tx_data), 32'h00);
        check({tag, "_stall_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_stall_addr"}, 32'(addr), 32'd0);
        ready_mode = rmode;
      end
      if (wr_test && !written && addr == 5'd2 && tx_valid) begin
        bank[3] = 32'h1234_5678;
        bank[2] = 32'hFFFF_FFFF;
        written = 1'b1;
      end
      if (done) begin
        seen  = 1'b1;
        start = poke;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (wr_test) check({tag, "_write_issued"}, 32'(written), 32'd1);
    step();
    start = 1'b0;
    check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
    check({tag, "_valid_after_done"}, 32'(tx_valid), 32'd0);
    repeat (12) step();
    check({tag, "_done_pulses"}, 32'(done_cnt - base_done), 32'd1);
    check({tag, "_byte_total"}, 32'(bytes_seen - base_bytes), 32'd128);
    check({tag, "_queue_left"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base_bytes;
    int base_done;
    for (int i = 0; i < 32; i++) begin
      bank[i]     = 32'(i);
      exp_bank[i] = 32'(i);
    end

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();

    // Initial bank, ready high, exact completion latency
    run_dump("t1", 0, 1'b0, 1'b0, 0);
    check("t1_done_cycle", 32'(last_done_cyc), 32'(e0 + 160));

    // Random backpressure with a distinctive word in reg 5
    bank[5]     = 32'hDEAD_BEEF;
    exp_bank[5] = 32'hDEAD_BEEF;
    run_dump("t2", 1, 1'b0, 1'b0, 0);

    // Extra start pulses mid-dump and in the DONE cycle
    run_dump("t3", 0, 1'b1, 1'b0, 0);

    // Bank write during reg 2: reg 3 picks it up, reg 2 keeps its captured value
    exp_bank[3] = 32'h1234_5678;
    run_dump("t6", 1, 1'b0, 1'b1, 0);
    exp_bank[2] = 32'hFFFF_FFFF;

    // Reset while reg 10 byte 2 is on offer
    base_bytes = bytes_seen;
    base_done  = done_cnt;
    push_dump();
    ready_mode = 0;
    ready      = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && (bytes_seen - base_bytes) < 42; i++) step();
    check("t4_reached_reg10_byte2", 32'(bytes_seen - base_bytes), 32'd42);
    check("t4_addr_before_reset", 32'(addr), 32'd10);
    ready_mode = 2;
    ready      = 1'b0;
    rst        = 1'b1;
    step();
    check("t4_valid_in_reset", 32'(tx_valid), 32'd0);
    check("t4_busy_in_reset", 32'(busy), 32'd0);
    check("t4_done_in_reset", 32'(done), 32'd0);
    check("t4_addr_in_reset", 32'(addr), 32'd0);
    rst = 1'b0;
    sb_q.delete();
    repeat (6) step();
    check("t4_no_done", 32'(done_cnt - base_done), 32'd0);
    check("t4_idle_busy", 32'(busy), 32'd0);

    // Fresh dump after reset, first byte stalled for 50 cycles
    run_dump("t5", 0, 1'b0, 1'b0, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
